// File: rtl/idu_ctrl_pipe_if.sv
// Handshake bundle between IFU, the decode control pipe and EXU.
// master drives instructions in and accepts control bundles out.
interface idu_ctrl_pipe_if #(
    parameter int PC_W = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [3:0]      out_aluct;
    logic [2:0]      out_extop;
    logic            out_regwr;
    logic            out_alu_asr;
    logic [1:0]      out_alu_bsr;
    logic [3:0]      out_branch;
    logic            out_memrd;
    logic            out_memwr;
    logic [2:0]      out_memop;
    logic            out_word;
    logic            out_ebreak;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
        input  out_aluct, out_extop, out_regwr, out_alu_asr, out_alu_bsr,
        input  out_branch, out_memrd, out_memwr, out_memop, out_word,
        input  out_ebreak, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
        output out_aluct, out_extop, out_regwr, out_alu_asr, out_alu_bsr,
        output out_branch, out_memrd, out_memwr, out_memop, out_word,
        output out_ebreak, out_illegal
    );
endinterface

// File: rtl/idu_ctrl_pipe.sv
// RV32I/RV64I control decoder with a 2-entry output buffer.
// One cycle of latency, full throughput while downstream is ready.
module idu_ctrl_pipe #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    idu_ctrl_pipe_if.slave bus
);
    localparam logic [3:0] A_ADD = 4'd0, A_PB = 4'd1, A_SUB = 4'd2;
    localparam logic [3:0] A_SLL = 4'd3, A_SRL = 4'd4, A_SRA = 4'd5;
    localparam logic [3:0] A_XOR = 4'd6, A_OR = 4'd7, A_AND = 4'd8;
    localparam logic [3:0] A_SLT = 4'd9, A_SLTU = 4'd10;
    localparam logic [2:0] E_R = 3'd1, E_I = 3'd2, E_S = 3'd3;
    localparam logic [2:0] E_B = 3'd4, E_U = 3'd5, E_J = 3'd6;
    localparam bit RV64 = (XLEN == 64);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [3:0]      aluct;
        logic [2:0]      extop;
        logic            regwr;
        logic            asr;
        logic [1:0]      bsr;
        logic [3:0]      branch;
        logic            memrd;
        logic            memwr;
        logic [2:0]      memop;
        logic            word;
        logic            ebreak;
        logic            illegal;
    } ent_t;

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        unique case (f3)
            3'b000: alu_of = alt ? A_SUB : A_ADD;
            3'b001: alu_of = A_SLL;
            3'b010: alu_of = A_SLT;
            3'b011: alu_of = A_SLTU;
            3'b100: alu_of = A_XOR;
            3'b101: alu_of = alt ? A_SRA : A_SRL;
            3'b110: alu_of = A_OR;
            default: alu_of = A_AND;
        endcase
    endfunction

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7z, f7a, shz, sha, ok;
    ent_t        dec;

    assign inst = bus.in_inst;
    assign opc  = inst[6:0];
    assign f3   = inst[14:12];
    assign f7z  = (inst[31:25] == 7'b0000000);
    assign f7a  = (inst[31:25] == 7'b0100000);
    // RV64 shift-immediates carry a 6-bit shamt, so only inst[31:26] is funct
    assign shz  = RV64 ? (inst[31:26] == 6'b000000) : f7z;
    assign sha  = RV64 ? (inst[31:26] == 6'b010000) : f7a;

    always_comb begin
        dec     = '0;
        ok      = 1'b0;
        dec.pc  = bus.in_pc;
        dec.rd  = inst[11:7];
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];
        unique case (opc)
            7'b0110111: begin
                ok = 1'b1; dec.aluct = A_PB; dec.extop = E_U; dec.regwr = 1'b1;
            end
            7'b0010111: begin
                ok = 1'b1; dec.extop = E_U; dec.regwr = 1'b1;
            end
            7'b1101111: begin
                ok = 1'b1; dec.extop = E_J; dec.regwr = 1'b1;
                dec.bsr = 2'd2; dec.branch = 4'd1;
            end
            7'b1100111: begin
                ok = (f3 == 3'b000); dec.extop = E_I; dec.regwr = 1'b1;
                dec.bsr = 2'd2; dec.branch = 4'd2;
            end
            7'b1100011: begin
                ok = (f3[2:1] != 2'b01); dec.aluct = A_SUB; dec.extop = E_B;
                dec.asr = 1'b1; dec.bsr = 2'd1; dec.branch = {1'b1, f3};
            end
            7'b0000011: begin
                ok = (f3 != 3'b111) && (RV64 || (f3 != 3'b011 && f3 != 3'b110));
                dec.extop = E_I; dec.asr = 1'b1; dec.regwr = 1'b1;
                dec.memrd = 1'b1; dec.memop = f3;
            end
            7'b0100011: begin
                ok = !f3[2] && (RV64 || f3 != 3'b011);
                dec.extop = E_S; dec.asr = 1'b1; dec.memwr = 1'b1; dec.memop = f3;
            end
            7'b0010011: begin
                ok = (f3 == 3'b001) ? shz : (f3 == 3'b101) ? (shz || sha) : 1'b1;
                dec.aluct = alu_of(f3, f3 == 3'b101 && sha);
                dec.extop = E_I; dec.asr = 1'b1; dec.regwr = 1'b1;
            end
            7'b0110011: begin
                ok = f7z || (f7a && (f3 == 3'b000 || f3 == 3'b101));
                dec.aluct = alu_of(f3, f7a);
                dec.extop = E_R; dec.asr = 1'b1; dec.bsr = 2'd1; dec.regwr = 1'b1;
            end
            7'b0011011: begin
                ok = RV64 && (f3 == 3'b000 || (f3 == 3'b001 && f7z)
                              || (f3 == 3'b101 && (f7z || f7a)));
                dec.aluct = alu_of(f3, f3 == 3'b101 && f7a);
                dec.extop = E_I; dec.asr = 1'b1; dec.regwr = 1'b1; dec.word = 1'b1;
            end
            7'b0111011: begin
                ok = RV64 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)
                     && (f7z || (f7a && f3 != 3'b001));
                dec.aluct = alu_of(f3, f7a);
                dec.extop = E_R; dec.asr = 1'b1; dec.bsr = 2'd1;
                dec.regwr = 1'b1; dec.word = 1'b1;
            end
            7'b1110011: begin
                ok = (inst == 32'h0010_0073); dec.ebreak = ok;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            dec.aluct   = '0;
            dec.extop   = '0;
            dec.regwr   = 1'b0;
            dec.asr     = 1'b0;
            dec.bsr     = '0;
            dec.branch  = '0;
            dec.memrd   = 1'b0;
            dec.memwr   = 1'b0;
            dec.memop   = '0;
            dec.word    = 1'b0;
            dec.ebreak  = 1'b0;
            dec.illegal = 1'b1;
        end
    end

    ent_t       mem_q [2];
    logic [1:0] cnt_q, cnt_d;
    logic       wr_q, wr_d, rd_q, rd_d;
    logic       push, pop;
    ent_t       head;

    assign bus.in_ready  = rst_n && (cnt_q != 2'd2);
    assign bus.out_valid = (cnt_q != 2'd0);
    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (flush) begin
            cnt_d = 2'd0;
            wr_d  = 1'b0;
            rd_d  = 1'b0;
        end else begin
            wr_d  = wr_q ^ push;
            rd_d  = rd_q ^ pop;
            cnt_d = cnt_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            if (push) mem_q[wr_q] <= dec;
        end
    end

    assign head            = mem_q[rd_q];
    assign bus.out_pc      = head.pc;
    assign bus.out_rd      = head.rd;
    assign bus.out_rs1     = head.rs1;
    assign bus.out_rs2     = head.rs2;
    assign bus.out_aluct   = head.aluct;
    assign bus.out_extop   = head.extop;
    assign bus.out_regwr   = head.regwr;
    assign bus.out_alu_asr = head.asr;
    assign bus.out_alu_bsr = head.bsr;
    assign bus.out_branch  = head.branch;
    assign bus.out_memrd   = head.memrd;
    assign bus.out_memwr   = head.memwr;
    assign bus.out_memop   = head.memop;
    assign bus.out_word    = head.word;
    assign bus.out_ebreak  = head.ebreak;
    assign bus.out_illegal = head.illegal;
endmodule

// File: doc/idu_ctrl_pipe.md
# idu_ctrl_pipe

Registered, parametrised RV32I/RV64I control decoder for the NPC instruction-decode stage. It accepts fetched instructions over a valid/ready handshake and produces the full control bundle: ALU op, immediate format, operand selects, branch kind, memory controls, register indices and an illegal flag. Output passes through a 2-entry buffer, so the decoder sits between IFU and EXU with one cycle of latency at full throughput.

## Interface
- XLEN, 64: 32 or 64; enables RV64 W/doubleword encodings when 64
- PC_W, 64: PC width carried through

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid / in_ready  in / out  1  upstream handshake
- in_inst  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid / out_ready  out / in  1  downstream handshake
- out_pc  out  PC_W; out_rd, out_rs1, out_rs2  out  5 each
- out_aluct  out  4  0 add, 1 pass-B, 2 sub, 3 sll, 4 srl, 5 sra, 6 xor, 7 or, 8 and, 9 slt, 10 sltu
- out_extop  out  3  0 none, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J
- out_regwr, out_alu_asr (0 PC, 1 rs1)  out  1
- out_alu_bsr  out  2  0 imm, 1 rs2, 2 constant 4
- out_branch  out  4  0 none, 1 jal, 2 jalr, 8+func3 conditional branch
- out_memrd, out_memwr  out  1; out_memop  out  3  load/store func3
- out_word  out  1  32-bit op (OP-32/OP-IMM-32)
- out_ebreak, out_illegal  out  1

## Operation
- Decode is combinational on in_inst; the result is written into the buffer on push (in_valid && in_ready).
- lui: pass-B, U, regwr. auipc: add, A=PC, U, regwr.
- jal: add, A=PC, B=4, J, regwr, branch 1. jalr (func3 000 only): same, but I format, branch 2.
- Branch (func3 000,001,100–111): sub, A=rs1, B=rs2, B format, branch 8+func3, regwr 0.
- Load: add, A=rs1, imm, I, regwr, memrd, memop=func3; legal func3 000,001,010,100,101, plus 011,110 when XLEN=64.
- Store: add, A=rs1, imm, S, memwr, memop=func3; func3 000–010, plus 011 when XLEN=64.
- OP-IMM / OP: ALU op from func3; func7 0000000, or 0100000 for sub (OP only) and sra. Shift-immediate checks inst[31:26] when XLEN=64, inst[31:25] when XLEN=32.
- OP-IMM-32 / OP-32: legal only when XLEN=64; set out_word.
- 0x00100073: out_ebreak=1, all writes 0.
- Anything else is illegal: out_illegal=1 and regwr, memrd, memwr, branch, ebreak all 0. The entry still flows downstream in order.
- rd/rs1/rs2 are always inst[11:7], [19:15], [24:20], regardless of format.

## Timing
- Buffer: 2-entry FIFO, count 0..2. in_ready = rst_n && count!=2, derived from registered state only. out_valid = count!=0. Head entry drives all out_* fields.
- Latency: a push at edge N is visible at out_* after edge N. Throughput is 1/cycle while out_ready=1.
- Push and pop in the same cycle: count unchanged; order preserved. At count=2 no push occurs, because in_ready=0.
- flush=1: count=0 at the next edge. The same-cycle push is dropped, and the same-cycle pop still completes for the handshake.
- out_* must stay stable while out_valid && !out_ready.
- Reset (asynchronous): count 0, all stored fields 0. Hence out_valid 0 and every out_* 0. in_ready is 0 while rst_n is low and 1 from the first cycle after release. Reset mid-stream discards all entries.

## Test plan
- 0x00500093 (addi x1,x0,5), out_ready=1 → next cycle: aluct 0, extop 2, asr 1, bsr 0, regwr 1, rd 1, rs1 0, illegal 0.
- 0x00008067 then 0x00209463 back-to-back → jalr: branch 2, asr 0, bsr 2, regwr 1. bne: branch 9, extop 4, aluct 2, bsr 1, regwr 0. Both appear on consecutive cycles.
- out_ready=0, push 3 instructions → two are accepted and in_ready drops after the 2nd. Raising out_ready drains them in order, and the 3rd is accepted once count<2.
- 0x0020B423 (sd) and 0x002080BB (addw) with XLEN=64 → sd: memwr 1, memop 3, extop 3. addw: word 1, aluct 0, regwr 1. With XLEN=32, both give illegal 1 and regwr/memwr 0.
- 0x00000000 → illegal 1, all write enables 0. 0x00100073 → ebreak 1, illegal 0.
- Buffer full, assert flush with in_valid=1 → out_valid 0 next cycle and nothing is enqueued. Reset pulse mid-stream → out_valid 0 immediately and all outputs 0.
